// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction/data memory handshake bundle for the multicycle control unit
interface multicycle_control_unit_if;
    logic i_mem_req;
    logic i_mem_ready;
    logic d_mem_req;
    logic d_mem_we;
    logic d_mem_ready;

    modport master (
        output i_mem_req,
        output d_mem_req,
        output d_mem_we,
        input  i_mem_ready,
        input  d_mem_ready
    );

    modport slave (
        input  i_mem_req,
        input  d_mem_req,
        input  d_mem_we,
        output i_mem_ready,
        output d_mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV64I control FSM with memory handshakes, timeout traps and retire counter
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_BITS     = 4,
    parameter int CNT_BITS    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     funct7_b5,
    input  logic [3:0]               alu_flags,
    multicycle_control_unit_if.master mem,
    output logic                     ir_we,
    output logic                     rf_we,
    output logic                     rf_src,
    output logic                     alu_src,
    output logic [3:0]               alu_cmd,
    output logic                     pc_we,
    output logic                     pc_src,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic [CNT_BITS-1:0]      retired
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_TRAP
    } state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [TO_BITS-1:0]  cnt_q, cnt_d;
    logic [1:0]          cause_q, cause_d;
    logic [CNT_BITS-1:0] retired_q, retired_d;

    logic is_op, is_imm, is_ld, is_st, is_br, br_bad;
    logic [3:0] exec_cmd;
    logic       taken;
    logic       i_req, d_req, d_we;
    logic       flag_z, flag_n, flag_c, flag_v;

    assign {flag_v, flag_c, flag_n, flag_z} = alu_flags;

    assign is_op  = (opcode == 7'b0110011);
    assign is_imm = (opcode == 7'b0010011);
    assign is_ld  = (opcode == 7'b0000011);
    assign is_st  = (opcode == 7'b0100011);
    assign is_br  = (opcode == 7'b1100011);
    assign br_bad = is_br && (funct3[2:1] == 2'b01);

    // funct7_b5 only selects SRA/SRAI among immediate ops; elsewhere it is immediate data
    always_comb begin
        exec_cmd = 4'b0000;
        if (is_op)       exec_cmd = {funct7_b5, funct3};
        else if (is_imm) exec_cmd = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = flag_z;
            3'b001:  taken = !flag_z;
            3'b100:  taken = flag_n ^ flag_v;
            3'b101:  taken = !(flag_n ^ flag_v);
            3'b110:  taken = !flag_c;
            3'b111:  taken = flag_c;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        rf_src     = 1'b0;
        alu_src    = 1'b0;
        alu_cmd    = 4'b0000;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'd0;
        case (state_q)
            S_FETCH: begin
                i_req = 1'b1;
                if (mem.i_mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (is_op || is_imm || is_ld || is_st) state_d = S_EXEC;
                else if (is_br && !br_bad)              state_d = S_BR;
                else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                alu_src = !is_op;
                alu_cmd = exec_cmd;
                state_d = (is_ld || is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                d_req   = 1'b1;
                d_we    = is_st;
                alu_src = 1'b1;
                alu_cmd = exec_cmd;
                if (mem.d_mem_ready) begin
                    cnt_d = '0;
                    if (is_st) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_src  = is_ld;
                alu_src = !is_op;
                alu_cmd = exec_cmd;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_BR: begin
                alu_cmd = 4'b0001;
                pc_we   = 1'b1;
                pc_src  = taken;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: state_d = S_TRAP;
        endcase
        // outputs must read all-zero the moment reset asserts, before the state flops settle
        if (!rst_n) begin
            i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; ir_we = 1'b0;
            rf_we = 1'b0; rf_src = 1'b0; alu_src = 1'b0; alu_cmd = 4'b0000;
            pc_we = 1'b0; pc_src = 1'b0; trap = 1'b0; trap_cause = 2'd0;
        end
    end

    assign retired_d     = retired_q + (pc_we ? CNT_BITS'(1) : CNT_BITS'(0));
    assign retired       = retired_q;
    assign mem.i_mem_req = i_req;
    assign mem.d_mem_req = d_req;
    assign mem.d_mem_we  = d_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            cause_q   <= 2'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end
endmodule
